// File: rtl/hdmi_text_axi_vram_bridge.sv
// ---------------------------------------------------------------------------
// hdmi_text_axi_vram_bridge
//
// AXI4-Lite slave for the HDMI text controller. Owns an inferred true-dual-port
// VRAM and a bank of colour-palette registers.
//   - VRAM port A: shared by the AXI read and write FSMs through a small
//     round-robin arbiter. It is a synchronous RAM, so reads pass through an
//     explicit wait state.
//   - VRAM port B: read-only video port (vid_addr -> vid_data, one cycle).
//   - Palette: NUM_PALETTE byte-strobed 32-bit registers at PAL_BASE, read
//     combinationally by the text mapper through pal_idx/pal_data.
//
// Optional feature macro: AXI_SLVERR_EN
//   defined   : unmapped accesses answer SLVERR (2'b10), RDATA = 0.
//   undefined : every response is OKAY; unmapped writes are dropped and
//               unmapped reads return 0.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW* / W* / B*         AXI4-Lite write address, data, response
//   S_AXI_AR* / R*              AXI4-Lite read address, data
//   vid_addr / vid_data         video read port (registered, 1-cycle latency)
//   pal_idx / pal_data          palette lookup (combinational)
//   dbg_wr_state/dbg_rd_state   current write / read FSM state
//
// Handshake rule: a transfer happens on a rising edge where VALID and READY
// are both high. Once raised, BVALID/RVALID and their payload stay put until
// the matching READY is seen.
// ---------------------------------------------------------------------------
module hdmi_text_axi_vram_bridge #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16,
    parameter int VRAM_DEPTH         = 2048,
    parameter int NUM_PALETTE        = 8,
    parameter int PAL_BASE           = 16'h2000,
    localparam int VRAM_AW           = $clog2(VRAM_DEPTH),
    localparam int PAL_AW            = $clog2(NUM_PALETTE)
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [VRAM_AW-1:0]                vid_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     vid_data,
    input  logic [PAL_AW-1:0]                 pal_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     pal_data,
    output logic [1:0]                        dbg_wr_state,
    output logic [1:0]                        dbg_rd_state
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int NB        = DW / 8;
    localparam int PAL_SLOTS = 1 << PAL_AW;

    // Decode bounds held one bit wider than a 32-bit address so the
    // end-of-region sums can never wrap.
    localparam logic [32:0] VRAM_END = 33'(VRAM_DEPTH) * 33'd4;
    localparam logic [32:0] PAL_LO   = 33'(PAL_BASE);
    localparam logic [32:0] PAL_HI   = 33'(PAL_BASE) + 33'(4 * NUM_PALETTE);
    localparam logic [PAL_AW-1:0] PAL_BASE_IDX = PAL_BASE[PAL_AW+1:2];

`ifdef AXI_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

    typedef enum logic [1:0] {TGT_NONE, TGT_VRAM, TGT_PAL} tgt_t;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    // Write channel holding registers
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [DW-1:0]                 w_data_q;
    logic [NB-1:0]                 w_strb_q;
    logic                          aw_held, w_held;
    logic                          aw_hs, w_hs;

    // Read channel registers
    logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr_q;
    logic [DW-1:0]                 rdata_q;
    logic [1:0]                    rresp_q, bresp_q;
    logic                          ar_hs;

    // Decoded targets
    tgt_t               aw_tgt, ar_tgt;
    logic [VRAM_AW-1:0] aw_word, ar_word;
    logic [PAL_AW-1:0]  aw_pal, ar_pal;

    // Storage
    logic [DW-1:0] palette [PAL_SLOTS];
    logic [DW-1:0] vram    [VRAM_DEPTH];

    // Port A and its arbiter
    logic               wr_vram_req, rd_vram_req;
    logic               wr_grant, rd_grant;
    logic               token_wr;           // 1: write side wins next contention
    logic [VRAM_AW-1:0] ram_addr_a;
    logic [NB-1:0]      ram_wea;
    logic [DW-1:0]      ram_dout_a;

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ---------------- address decode ----------------
    always_comb begin
        aw_tgt = TGT_NONE;
        if (33'(aw_addr_q) < VRAM_END)
            aw_tgt = TGT_VRAM;
        else if (33'(aw_addr_q) >= PAL_LO && 33'(aw_addr_q) < PAL_HI)
            aw_tgt = TGT_PAL;
    end

    always_comb begin
        ar_tgt = TGT_NONE;
        if (33'(ar_addr_q) < VRAM_END)
            ar_tgt = TGT_VRAM;
        else if (33'(ar_addr_q) >= PAL_LO && 33'(ar_addr_q) < PAL_HI)
            ar_tgt = TGT_PAL;
    end

    // PAL_BASE is word aligned, so the low index bits subtract exactly.
    assign aw_word = aw_addr_q[VRAM_AW+1:2];
    assign ar_word = ar_addr_q[VRAM_AW+1:2];
    assign aw_pal  = aw_addr_q[PAL_AW+1:2] - PAL_BASE_IDX;
    assign ar_pal  = ar_addr_q[PAL_AW+1:2] - PAL_BASE_IDX;

    // ---------------- port-A arbiter ----------------
    assign wr_vram_req = (wr_state == W_EXEC) && (aw_tgt == TGT_VRAM);
    assign rd_vram_req = (rd_state == R_REQ)  && (ar_tgt == TGT_VRAM);

    always_comb begin
        wr_grant = wr_vram_req;
        rd_grant = rd_vram_req;
        if (wr_vram_req && rd_vram_req) begin
            wr_grant = token_wr;
            rd_grant = !token_wr;
        end
    end

    // Token only moves when both sides actually collided.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET)
            token_wr <= 1'b1;
        else if (wr_vram_req && rd_vram_req)
            token_wr <= !token_wr;
    end

    assign ram_addr_a = wr_grant ? aw_word : ar_word;
    assign ram_wea    = wr_grant ? w_strb_q : '0;

    // ---------------- VRAM (true dual port, not reset) ----------------
    // Port B reads with non-blocking semantics, so a same-address port-A
    // write in the same cycle returns the old word.
    always_ff @(posedge S_AXI_ACLK) begin
        for (int i = 0; i < NB; i++) begin
            if (ram_wea[i])
                vram[ram_addr_a][8*i +: 8] <= w_data_q[8*i +: 8];
        end
        ram_dout_a <= vram[ram_addr_a];
        vid_data   <= vram[vid_addr];
    end

    // ---------------- write FSM ----------------
    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

    always_comb begin
        wr_next       = wr_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                S_AXI_AWREADY = !aw_held && !S_AXI_ARESET;
                S_AXI_WREADY  = !w_held  && !S_AXI_ARESET;
                if ((aw_held || aw_hs) && (w_held || w_hs))
                    wr_next = W_EXEC;
            end
            W_EXEC: begin
                if (aw_tgt != TGT_VRAM || wr_grant)
                    wr_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY)
                    wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state  <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= 2'b00;
            for (int p = 0; p < PAL_SLOTS; p++)
                palette[p] <= '0;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) begin
                aw_addr_q <= S_AXI_AWADDR;
                aw_held   <= 1'b1;
            end
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
                w_held   <= 1'b1;
            end
            // Leaving idle consumes both halves; the payload stays in the
            // holding registers until the next capture.
            if (wr_state == W_IDLE && wr_next == W_EXEC) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (wr_state == W_EXEC) begin
                if (aw_tgt == TGT_PAL) begin
                    for (int i = 0; i < NB; i++) begin
                        if (w_strb_q[i])
                            palette[aw_pal][8*i +: 8] <= w_data_q[8*i +: 8];
                    end
                end
                bresp_q <= (aw_tgt == TGT_NONE) ? UNMAPPED_RESP : 2'b00;
            end
        end
    end

    assign S_AXI_BRESP = bresp_q;

    // ---------------- read FSM ----------------
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        rd_next       = rd_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                S_AXI_ARREADY = !S_AXI_ARESET;
                if (ar_hs)
                    rd_next = R_REQ;
            end
            R_REQ: begin
                if (ar_tgt != TGT_VRAM)
                    rd_next = R_RESP;
                else if (rd_grant)
                    rd_next = R_WAIT;
            end
            R_WAIT: rd_next = R_RESP;
            R_RESP: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY)
                    rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state  <= R_IDLE;
            ar_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            rd_state <= rd_next;
            if (ar_hs)
                ar_addr_q <= S_AXI_ARADDR;
            if (rd_state == R_REQ) begin
                case (ar_tgt)
                    TGT_PAL: begin
                        rdata_q <= palette[ar_pal];
                        rresp_q <= 2'b00;
                    end
                    TGT_VRAM: rresp_q <= 2'b00;
                    default: begin
                        rdata_q <= '0;
                        rresp_q <= UNMAPPED_RESP;
                    end
                endcase
            end
            // Port-A output is valid the cycle after the granted request.
            if (rd_state == R_WAIT)
                rdata_q <= ram_dout_a;
        end
    end

    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    assign pal_data     = palette[pal_idx];
    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

endmodule
